// File: rtl/cla_issue_ctrl_if.sv
// Request/response bundle for cla_issue_ctrl.
// The master side is the request source plus the result consumer; the slave
// side is the controller. out_ovf exists only when CLA_SIGNED_OVF_EN is defined.
interface cla_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
`ifdef CLA_SIGNED_OVF_EN
  logic        out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef CLA_SIGNED_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef CLA_SIGNED_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/cla_issue_ctrl.sv
// Issue/return controller around a registered carry-lookahead adder.
// Operands pass straight through to the adder; a valid shift register follows
// each accepted op through the adder latency and its result lands in a small
// FIFO. Issue is credit-limited (FIFO occupancy + ops in flight < DEPTH) so a
// result can never arrive at a full FIFO.
// Optional: define CLA_SIGNED_OVF_EN to add the out_ovf signed-overflow flag,
// carried as a 2-bit operand-sign sideband alongside each op.
module cla_issue_ctrl #(
  parameter int ADD_LAT = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_issue_ctrl_if.slave  bus,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_cin,
  input  logic [31:0]      add_sum,
  input  logic             add_cout,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [ADD_LAT-1:0] vld_q, vld_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
  logic [32:0]        mem_q [DEPTH];
  logic [32:0]        mem_d [DEPTH];

  logic fire, push, pop, in_ready;
  int   inflight;

  assign add_a   = bus.in_a;
  assign add_b   = bus.in_b;
  assign add_cin = bus.in_cin;

  // Credit check; uses only registered state so out_ready never reaches in_ready.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < ADD_LAT; i++) begin
      inflight = inflight + int'(vld_q[i]);
    end
    in_ready = !rst && ((int'(count_q) + inflight) < DEPTH);
  end

  assign bus.in_ready  = in_ready;
  assign fire          = bus.in_valid & in_ready;
  assign push          = vld_q[ADD_LAT-1];
  assign pop           = (count_q != '0) & bus.out_ready;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_sum   = mem_q[rd_ptr_q][31:0];
  assign bus.out_cout  = mem_q[rd_ptr_q][32];
  assign issued_cnt    = issued_cnt_q;

  // Next-state for tracking, FIFO pointers/occupancy, storage and statistics.
  always_comb begin
    vld_d[0] = fire;
    for (int i = 1; i < ADD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {add_cout, add_sum};
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    issued_cnt_d = issued_cnt_q + CNT_W'(fire);
  end

  // Control state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      issued_cnt_q <= '0;
    end else begin
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // Result storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef CLA_SIGNED_OVF_EN
  logic [1:0] sb_q     [ADD_LAT];
  logic [1:0] sb_d     [ADD_LAT];
  logic [1:0] sb_mem_q [DEPTH];
  logic [1:0] sb_mem_d [DEPTH];
  logic [1:0] sb_head;

  // Operand sign bits ride alongside the op, aligned with vld, then into a FIFO column.
  always_comb begin
    sb_d[0] = {bus.in_a[31], bus.in_b[31]};
    for (int i = 1; i < ADD_LAT; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    sb_mem_d = sb_mem_q;
    if (push) begin
      sb_mem_d[wr_ptr_q] = sb_q[ADD_LAT-1];
    end
  end

  // Sideband storage; qualified by vld/count like the main datapath.
  always_ff @(posedge clk) begin
    sb_q     <= sb_d;
    sb_mem_q <= sb_mem_d;
  end

  assign sb_head     = sb_mem_q[rd_ptr_q];
  assign bus.out_ovf = bus.out_valid & (sb_head[1] == sb_head[0]) &
                       (bus.out_sum[31] != sb_head[1]);
`endif

endmodule

// File: tb/tb_cla_issue_ctrl.sv
// Directed bench for cla_issue_ctrl with a behavioural registered adder.
module tb_cla_issue_ctrl;
  localparam int ADD_LAT = 2;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst;
  logic [31:0]      add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [CNT_W-1:0] issued_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int push_full_err = 0;

  cla_issue_ctrl_if bus ();

  cla_issue_ctrl #(.ADD_LAT(ADD_LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered adder model, ADD_LAT stages, no reset.
  logic [32:0] apipe [ADD_LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum  = apipe[ADD_LAT-1][31:0];
  assign add_cout = apipe[ADD_LAT-1][32];

  // A push into a full FIFO must never happen.
  always @(negedge clk) begin
    if (!rst && dut.vld_q[ADD_LAT-1] && (int'(dut.count_q) == DEPTH)) push_full_err++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1, return edges from fire to out_valid (-1 on timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output int lat, output logic [31:0] s, output logic c, output logic o);
    int w;
    s = '0; c = 1'b0; o = 1'b0; lat = -1;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin tick(); w++; end
    if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
    tick();
    bus.in_valid = 1'b0;
    w = 1;
    while (!bus.out_valid && w < 20) begin tick(); w++; end
    if (!bus.out_valid) return;
    lat = w;
    s = bus.out_sum;
    c = bus.out_cout;
`ifdef CLA_SIGNED_OVF_EN
    o = bus.out_ovf;
`endif
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (issued_cnt !== 16'd0) begin n_err++; $display("FAIL reset_issued_cnt: got %0d want 0", issued_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int lat; logic [31:0] s; logic c, o;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, s, c, o);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", lat); end
    n_cmp++; if (s !== 32'h0) begin n_err++; $display("FAIL single_sum: got %h want 00000000", s); end
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL single_cout: got %b want 1", c); end
    n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL single_issued_cnt: got %0d want 1", issued_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int rcv = 0;
    logic [31:0] exp_s;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 8) begin
        bus.in_a = 32'(cyc); bus.in_b = 32'(16 * cyc); bus.in_cin = cyc[0]; bus.in_valid = 1'b1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready op%0d: got %b want 1", cyc, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        exp_s = 32'(17 * rcv + (rcv % 2));
        n_cmp++; if (bus.out_sum !== exp_s || bus.out_cout !== 1'b0) begin
          n_err++; $display("FAIL b2b_result op%0d: got %h/%b want %h/0", rcv, bus.out_sum, bus.out_cout, exp_s);
        end
        rcv++;
      end else if (rcv > 0 && rcv < 8) begin
        n_cmp++; n_err++; $display("FAIL b2b_gap: got out_valid 0 at result %0d want 1", rcv);
      end
      tick();
    end
    n_cmp++; if (rcv !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", rcv); end
  endtask

  task automatic test_backpressure();
    int acc = 0, rcv = 0;
    logic [CNT_W-1:0] cnt0, diff;
    bit check_next = 0;
    cnt0 = issued_cnt;
    bus.out_ready = 1'b0;
    bus.in_a = 32'd5; bus.in_b = 32'd7; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.in_ready) acc++;
      tick();
    end
    diff = issued_cnt - cnt0;
    n_cmp++; if (acc !== DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
    n_cmp++; if (diff !== 16'd4) begin n_err++; $display("FAIL bp_issued_delta: got %0d want 4", diff); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.out_valid) begin
        n_cmp++; if (bus.out_sum !== 32'h0000_000C || bus.out_cout !== 1'b0) begin
          n_err++; $display("FAIL bp_result%0d: got %h/%b want 0000000c/0", rcv, bus.out_sum, bus.out_cout);
        end
        if (rcv == 0) begin
          n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_same_cycle_credit: got %b want 0", bus.in_ready); end
          check_next = 1;
        end
        rcv++;
      end
      tick();
      if (check_next) begin
        check_next = 0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_credit_return: got %b want 1", bus.in_ready); end
      end
    end
    n_cmp++; if (rcv !== 4) begin n_err++; $display("FAIL bp_drain_count: got %0d want 4", rcv); end
  endtask

  task automatic test_push_pop_near_full();
    logic [31:0] exp_q [3];
    int rcv = 0;
    exp_q[0] = 32'h202; exp_q[1] = 32'h303; exp_q[2] = 32'h404;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_a = 32'(i * 256); bus.in_b = 32'(i); bus.in_cin = 1'b0; bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL pp_ready_at_3: got %b want 1", bus.in_ready); end
    bus.in_a = 32'h400; bus.in_b = 32'h4; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL pp_credit_inflight: got %b want 0", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_sum !== 32'h101) begin n_err++; $display("FAIL pp_head_before: got %h want 00000101", bus.out_sum); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (int'(dut.count_q) !== DEPTH - 1) begin n_err++; $display("FAIL pp_count_unchanged: got %0d want %0d", dut.count_q, DEPTH - 1); end
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.out_valid) begin
        if (rcv < 3) begin
          n_cmp++; if (bus.out_sum !== exp_q[rcv]) begin n_err++; $display("FAIL pp_order%0d: got %h want %h", rcv, bus.out_sum, exp_q[rcv]); end
        end
        rcv++;
      end
      tick();
    end
    n_cmp++; if (rcv !== 3) begin n_err++; $display("FAIL pp_drain_count: got %0d want 3", rcv); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0, lat; logic [31:0] s; logic c, o;
    bus.out_ready = 1'b1;
    bus.in_a = 32'd10; bus.in_b = 32'd20; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    tick(); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (issued_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_issued_cnt: got %0d want 0", issued_cnt); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_stale_valid: got %0d cycles want 0", seen); end
    do_op(32'd1, 32'd2, 1'b0, lat, s, c, o);
    n_cmp++; if (lat !== 3 || s !== 32'd3 || c !== 1'b0) begin n_err++; $display("FAIL rst_mid_fresh_op: got lat %0d sum %h cout %b want 3/00000003/0", lat, s, c); end
    n_cmp++; if (issued_cnt !== 16'd1) begin n_err++; $display("FAIL rst_mid_fresh_cnt: got %0d want 1", issued_cnt); end
  endtask

`ifdef CLA_SIGNED_OVF_EN
  task automatic test_signed_ovf();
    int lat; logic [31:0] s; logic c, o;
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, lat, s, c, o);
    n_cmp++; if (o !== 1'b1 || s !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_pos: got ovf %b sum %h want 1/80000000", o, s); end
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, s, c, o);
    n_cmp++; if (o !== 1'b1 || s !== 32'h0 || c !== 1'b1) begin n_err++; $display("FAIL ovf_neg: got ovf %b sum %h cout %b want 1/00000000/1", o, s, c); end
    do_op(32'h1, 32'h1, 1'b0, lat, s, c, o);
    n_cmp++; if (o !== 1'b0 || s !== 32'h2) begin n_err++; $display("FAIL ovf_none: got ovf %b sum %h want 0/00000002", o, s); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got %b want 0", bus.out_ovf); end
  endtask
`endif

  task automatic test_no_overflow();
    n_cmp++; if (push_full_err !== 0) begin n_err++; $display("FAIL push_while_full: got %0d events want 0", push_full_err); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop_near_full();
    test_reset_midflight();
`ifdef CLA_SIGNED_OVF_EN
    test_signed_ovf();
`endif
    test_no_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_issue_ctrl.md
Name: cla_issue_ctrl

Overview:
- Issue/return controller wrapped around the registered 32-bit carry-lookahead adder.
- Accepts add requests (a, b, cin) on a valid/ready interface and drives the adder's operand inputs.
- Tracks each operation through the adder's fixed pipeline latency, then captures sum/cout into a small result FIFO with downstream backpressure.
- Credit-based issue guarantees no result is ever dropped.

Parameters:
- ADD_LAT, 2: adder latency in clock edges, from operand capture to valid sum/cout at adder output; legal values ≥1.
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- CNT_W, 16: width of issued-operation statistics counter.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept request this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_cin  in  1  carry in
- add_a  out  32  to adder operand A
- add_b  out  32  to adder operand B
- add_cin  out  1  to adder carry in
- add_sum  in  32  from adder registered sum
- add_cout  in  1  from adder registered carry out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  32  result sum (FIFO head)
- out_cout  out  1  result carry (FIFO head)
- issued_cnt  out  CNT_W  operations issued since reset, wraps

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. All state updates on rising clk only.
- Reset values (after the edge with rst=1): valid shift register all 0, FIFO rd/wr pointers 0, count 0, out_valid 0, issued_cnt 0. in_ready=0 while rst=1 and 1 from the first cycle after reset. out_sum/out_cout are don't-care while out_valid=0.
- Adder internal registers are not reset. Garbage emerging from them is ignored because the valid bits are cleared.
- Operand path:
  - add_a/add_b/add_cin = in_a/in_b/in_cin, combinational pass-through.
  - The adder samples them every edge; only edges where fire_in = in_valid & in_ready are tracked.
- Tracking:
  - vld[ADD_LAT-1:0] shift register; vld[0] <= fire_in; vld[i] <= vld[i-1].
  - When vld[ADD_LAT-1]=1, add_sum/add_cout are valid that cycle and are written to the FIFO at the next edge.
  - Latency from the fire_in edge to out_valid=1 is ADD_LAT+1 edges (3 by default).
- Credits:
  - inflight = popcount(vld).
  - in_ready = !rst & (count + inflight < DEPTH).
  - A pop in the same cycle does not raise in_ready; the credit becomes visible next cycle. This keeps in_ready free of any path from out_ready.
- FIFO:
  - push = vld[ADD_LAT-1]; pop = out_valid & out_ready.
  - out_valid = (count != 0). out_sum/out_cout show the head entry, registered storage.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full cannot occur by construction. Verification asserts this.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
- issued_cnt increments on fire_in and wraps from 2^CNT_W−1 to 0.
- Ordering: results leave in issue order.
- Throughput: one op/cycle sustained while out_ready=1.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded. No out_valid for them after reset.
- in_valid with in_ready=0: the request is not consumed; the source must hold its operands.

Optional Feature:
- Macro: CLA_SIGNED_OVF_EN.
- When defined:
  - Adds output port out_ovf (1 bit) and a 2-bit sideband (in_a[31], in_b[31]) per op. The sideband is carried in a parallel ADD_LAT shift register and FIFO column.
  - out_ovf = (a31 == b31) & (out_sum[31] != a31) for the head entry.
  - out_ovf resets to 0.
- When not defined: the port, sideband storage and logic are absent. All other behaviour is identical.

Test Plan:
- Single op, idle sink: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → out_valid rises 3 edges after fire; sum=0x00000000, cout=1; issued_cnt=1.
- Back-to-back stream: 8 ops (a=i, b=0x10·i, cin=i[0]) issued consecutively, out_ready=1 → in_ready stays 1; 8 results in order, e.g. op 3 gives sum=0x00000034; no gaps after the first.
- Backpressure: out_ready=0, in_valid held 1 with a=5, b=7 → exactly DEPTH=4 ops accepted, then in_ready=0. Raise out_ready: four results of 0x0000000C drain; in_ready returns 1 the cycle after the first pop.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle while vld is nonzero → out_valid never asserts for those ops; issued_cnt=0; a fresh op 1+2 returns 3.
- Simultaneous push/pop at count=DEPTH−1 → count unchanged, no overflow assertion, data order preserved.
- CLA_SIGNED_OVF_EN: a=0x7FFFFFFF, b=1 → out_ovf=1, sum=0x80000000. a=0x80000000, b=0x80000000 → out_ovf=1, sum=0, cout=1. a=1, b=1 → out_ovf=0.
